// File: rtl/fsm_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : fsm_seq_pkg                                                |
// | Purpose  : Phase encodings shared with the A-sequence responder and   |
// |            the stimulus transmitter state enumeration.                |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package fsm_seq_pkg;

   // Expected responder phase, as reported on the transmitter Phase output
   localparam logic [1:0] PH_IDLE  = 2'b00;
   localparam logic [1:0] PH_START = 2'b01;
   localparam logic [1:0] PH_STOP  = 2'b10;
   localparam logic [1:0] PH_CLEAR = 2'b11;

   // Transmitter sequencing states: idle plus the four dwell phases of A
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HIGH1 = 3'd1,
      S_LOW1  = 3'd2,
      S_HIGH2 = 3'd3,
      S_LOW2  = 3'd4
   } tx_state_e;

endpackage : fsm_seq_pkg
`default_nettype wire

// File: rtl/dwell_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dwell_cnt                                                  |
// | Purpose  : Loadable down-counter timing each stimulus phase; flags    |
// |            zero on the last cycle of a phase.                         |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module dwell_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q, count_d;

   // Load has priority; decrement stops at zero so the count never wraps
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Count register with synchronous active-low reset
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule : dwell_cnt
`default_nettype wire

// File: rtl/fsm_stim_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fsm_stim_tx                                                |
// | Purpose  : Drives A high/low/high/low with programmable dwell, checks |
// |            responder K2/K1 acks in their windows, pulses Done/Err.    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module fsm_stim_tx
   import fsm_seq_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Go_i,
   input  logic [CNT_W-1:0] Len_i,
   input  logic             K2_i,
   input  logic             K1_i,
   output logic             A_o,
   output logic             Busy_o,
   output logic             Done_o,
   output logic             Err_o,
   output logic [1:0]       Phase_o
);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] len_eff;
   logic             seen_k2_q, seen_k2_d;
   logic             seen_k1_q, seen_k1_d;
   logic             cnt_load, cnt_en, cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;
   logic             a_q, a_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [1:0]       phase_q, phase_d;

   // A zero length request behaves as a one-cycle dwell
   assign len_eff = (Len_i == '0) ? CNT_W'(1) : Len_i;

   dwell_cnt #(.CNT_W(CNT_W)) u_dwell_cnt (
      .Clock      (Clock),
      .Reset      (Reset),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .en_i       (cnt_en),
      .zero_o     (cnt_zero)
   );

   // Next-state, ack tracking and output decode from the next state
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      seen_k2_d    = seen_k2_q;
      seen_k1_d    = seen_k1_q;
      cnt_load     = 1'b0;
      cnt_load_val = len_q - CNT_W'(1);
      cnt_en       = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      a_d          = 1'b0;
      busy_d       = 1'b1;
      phase_d      = PH_IDLE;

      case (state_q)
         S_IDLE: begin
            if (Go_i) begin
               len_d        = len_eff;
               cnt_load     = 1'b1;
               cnt_load_val = len_eff - CNT_W'(1);
               seen_k2_d    = 1'b0;
               seen_k1_d    = 1'b0;
               state_d      = S_HIGH1;
            end
         end
         S_HIGH1: begin
            if (cnt_zero) begin
               cnt_load = 1'b1;
               state_d  = S_LOW1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_LOW1: begin
            if (cnt_zero) begin
               cnt_load = 1'b1;
               state_d  = S_HIGH2;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_HIGH2: begin
            if (K2_i) seen_k2_d = 1'b1;
            if (cnt_zero) begin
               cnt_load = 1'b1;
               state_d  = S_LOW2;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_LOW2: begin
            if (K1_i) seen_k1_d = 1'b1;
            if (cnt_zero) begin
               // The final cycle's K1 counts, hence seen_k1_d here
               state_d = S_IDLE;
               done_d  = 1'b1;
               err_d   = !(seen_k2_q && seen_k1_d);
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_HIGH1: begin a_d = 1'b1; phase_d = PH_START; end
         S_LOW1:  begin a_d = 1'b0; phase_d = PH_STOP;  end
         S_HIGH2: begin a_d = 1'b1; phase_d = PH_CLEAR; end
         S_LOW2:  begin a_d = 1'b0; phase_d = PH_IDLE;  end
         default: busy_d = 1'b0;
      endcase
   end

   // State, latched length, ack flags and registered outputs
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         seen_k2_q <= 1'b0;
         seen_k1_q <= 1'b0;
         a_q       <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         phase_q   <= PH_IDLE;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         seen_k2_q <= seen_k2_d;
         seen_k1_q <= seen_k1_d;
         a_q       <= a_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         phase_q   <= phase_d;
      end
   end

   assign A_o     = a_q;
   assign Busy_o  = busy_q;
   assign Done_o  = done_q;
   assign Err_o   = err_q;
   assign Phase_o = phase_q;

endmodule : fsm_stim_tx
`default_nettype wire

// File: tb/tb_fsm_stim_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_fsm_stim_tx                                             |
// | Purpose  : Randomized self-checking bench for fsm_stim_tx against a   |
// |            cycle-index reference model of the A sequence.             |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_fsm_stim_tx;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       Go_i  = 1'b0;
   logic [7:0] Len_i = 8'd0;
   logic       K2_i  = 1'b0;
   logic       K1_i  = 1'b0;
   logic       A_o, Busy_o, Done_o, Err_o;
   logic [1:0] Phase_o;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: m_t is the cycle index within a running sequence
   // (1..4L), 0 when idle; m_done/m_err describe the current cycle.
   int m_t  = 0;
   int m_L  = 1;
   bit m_sk1, m_sk2, m_done, m_err;

   fsm_stim_tx #(.CNT_W(8)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Go_i    (Go_i),
      .Len_i   (Len_i),
      .K2_i    (K2_i),
      .K1_i    (K1_i),
      .A_o     (A_o),
      .Busy_o  (Busy_o),
      .Done_o  (Done_o),
      .Err_o   (Err_o),
      .Phase_o (Phase_o)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // One clock cycle: responder model drives K, inputs applied, edge,
   // reference model advanced, all outputs compared.
   // kmode: 0 good, 1 K1 stuck 0, 2 K2 stuck 0, 3 K2 only in Stop phase, 4 random
   task automatic step(input bit rst_n, input bit go, input int len, input int kmode);
      bit k1, k2;
      bit busy_e, a_e;
      int ph_e, idx;
      case (kmode)
         0: begin k2 = (Phase_o == 2'b11); k1 = (Phase_o == 2'b00) && Busy_o; end
         1: begin k2 = (Phase_o == 2'b11); k1 = 1'b0; end
         2: begin k2 = 1'b0; k1 = (Phase_o == 2'b00) && Busy_o; end
         3: begin k2 = (Phase_o == 2'b10); k1 = (Phase_o == 2'b00) && Busy_o; end
         default: begin k2 = 1'($urandom); k1 = 1'($urandom); end
      endcase
      Reset = rst_n;
      Go_i  = go;
      Len_i = len[7:0];
      K2_i  = k2;
      K1_i  = k1;
      @(posedge Clock);
      #1;
      if (!rst_n) begin
         m_t = 0; m_done = 0; m_err = 0; m_sk1 = 0; m_sk2 = 0;
      end else begin
         m_done = 0;
         m_err  = 0;
         if (m_t > 0) begin
            if (m_t > 2*m_L && m_t <= 3*m_L && k2) m_sk2 = 1;
            if (m_t > 3*m_L && k1) m_sk1 = 1;
            if (m_t == 4*m_L) begin
               m_t    = 0;
               m_done = 1;
               m_err  = !(m_sk2 && m_sk1);
            end else begin
               m_t++;
            end
         end else if (go) begin
            m_L   = (len[7:0] == 8'd0) ? 1 : int'(len[7:0]);
            m_t   = 1;
            m_sk1 = 0;
            m_sk2 = 0;
         end
      end
      busy_e = (m_t > 0);
      idx    = busy_e ? (m_t - 1) / m_L : 0;
      a_e    = busy_e && (idx % 2 == 0);
      ph_e   = busy_e ? (idx + 1) % 4 : 0;
      chk("A",     int'(A_o),     int'(a_e));
      chk("Busy",  int'(Busy_o),  int'(busy_e));
      chk("Phase", int'(Phase_o), ph_e);
      chk("Done",  int'(Done_o),  int'(m_done));
      chk("Err",   int'(Err_o),   int'(m_err));
   endtask

   // Launch one sequence and run to its Done; optional random Go/Len noise
   task automatic run_seq(input int len, input int kmode, input bit noise);
      int lim;
      lim = 4 * 256 + 8;
      step(1, 1, len, kmode);
      for (int i = 0; i < lim; i++) begin
         step(1, noise ? 1'($urandom) : 1'b0, noise ? int'($urandom_range(0, 255)) : len, kmode);
         if (m_done) break;
      end
      if (!m_done) chk("seq_timeout", 0, 1);
   endtask

   initial begin
      // Reset held with Go pulsed: Go must be ignored
      step(0, 1, 5, 0);
      step(0, 1, 5, 0);
      step(1, 0, 5, 0);
      step(1, 0, 5, 0);

      run_seq(3, 0, 0);
      step(1, 0, 0, 0);
      run_seq(2, 1, 0);
      run_seq(2, 2, 0);
      run_seq(2, 3, 0);
      run_seq(0, 0, 0);
      run_seq(255, 0, 0);
      step(1, 0, 0, 0);

      // Go held high: back-to-back sequences with one idle cycle between
      for (int i = 0; i < 24; i++) step(1, 1, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 0, 1, 0);

      // Reset in the second high phase aborts without Done
      step(1, 1, 4, 0);
      for (int i = 0; i < 20 && m_t != 10; i++) step(1, 0, 4, 0);
      chk("reached_high2", m_t, 10);
      step(0, 1, 4, 0);
      step(1, 0, 4, 0);
      step(1, 0, 4, 0);
      run_seq(4, 0, 0);

      // Randomized sequences with Go/Len noise while busy
      for (int s = 0; s < 30; s++) begin
         run_seq($urandom_range(0, 12), $urandom_range(0, 4), 1'($urandom));
         if ($urandom_range(0, 1) == 1) step(1, 0, 0, 4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_fsm_stim_tx
`default_nettype wire
